// File: rtl/split_bus_arbiter.sv
// Bus arbiter in front of split_target: grants one initiator at a time, parks split reads.
// Optional SPLIT_ARB_RR_EN selects round-robin arbitration; the default is fixed priority (lowest index).

// Per-initiator qualification: masking of the parked initiator and detection of a foreign release.
module split_bus_arbiter_lane #(
  parameter int IW  = 1,
  parameter int IDX = 0
) (
  input  logic          req,
  input  logic          done,
  input  logic          split_pending,
  input  logic          own_active,
  input  logic [IW-1:0] split_owner,
  input  logic [IW-1:0] own_idx,
  output logic          elig,
  output logic          stray_done
);
  assign elig       = req  & ~(split_pending & (split_owner == IW'(IDX)));
  assign stray_done = done & ~(own_active & (own_idx == IW'(IDX)));
endmodule

module split_bus_arbiter #(
  parameter  int NUM_INIT     = 2,
  parameter  int HOLD_TIMEOUT = 0,
  localparam int IW           = $clog2(NUM_INIT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_INIT-1:0] init_req,
  input  logic [NUM_INIT-1:0] init_done,
  input  logic                target_split_ack,
  input  logic                target_ack,
  input  logic                split_req,
  output logic [NUM_INIT-1:0] init_grant,
  output logic                split_grant,
  output logic [IW-1:0]       split_owner,
  output logic                split_pending,
  output logic                bus_busy,
  output logic                arb_timeout,
  output logic                split_err
);
  localparam int HCW = $clog2(HOLD_TIMEOUT + 2);

  typedef enum logic [1:0] {ST_IDLE, ST_INIT_OWN, ST_SPLIT_OWN} state_t;

  state_t              state, state_nxt;
  logic [IW-1:0]       own_idx, own_nxt;
  logic [HCW-1:0]      hold_cnt, hold_nxt;
  logic [NUM_INIT-1:0] grant_nxt;
  logic                sgrant_nxt, spend_nxt, tmo_nxt, err_nxt, busy_nxt;
  logic [IW-1:0]       sowner_nxt;
  logic [NUM_INIT-1:0] elig, stray_done;
  logic                win_vld;
  logic [IW-1:0]       win_idx;

  for (genvar i = 0; i < NUM_INIT; i++) begin : g_lane
    split_bus_arbiter_lane #(.IW(IW), .IDX(i)) u_lane (
      .req          (init_req[i]),
      .done         (init_done[i]),
      .split_pending(split_pending),
      .own_active   (state == ST_INIT_OWN),
      .split_owner  (split_owner),
      .own_idx      (own_idx),
      .elig         (elig[i]),
      .stray_done   (stray_done[i])
    );
  end

`ifdef SPLIT_ARB_RR_EN
  logic [IW-1:0] rr_ptr, rr_nxt;

  // Descending scan: the last hit is the eligible index closest after rr_ptr.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NUM_INIT - 1; k >= 0; k--) begin
      if (elig[(int'(rr_ptr) + k) % NUM_INIT]) begin
        win_vld = 1'b1;
        win_idx = IW'((int'(rr_ptr) + k) % NUM_INIT);
      end
    end
  end

  always_comb begin
    rr_nxt = rr_ptr;
    if (state == ST_IDLE && !(split_req && split_pending) && win_vld)
      rr_nxt = (int'(win_idx) == NUM_INIT - 1) ? '0 : win_idx + IW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr <= '0;
    else        rr_ptr <= rr_nxt;
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NUM_INIT - 1; k >= 0; k--) begin
      if (elig[k]) begin
        win_vld = 1'b1;
        win_idx = IW'(k);
      end
    end
  end
`endif

  always_comb begin
    state_nxt  = state;
    own_nxt    = own_idx;
    hold_nxt   = hold_cnt;
    grant_nxt  = init_grant;
    sgrant_nxt = split_grant;
    sowner_nxt = split_owner;
    spend_nxt  = split_pending;
    tmo_nxt    = 1'b0;
    err_nxt    = split_err
               | (split_req & ~split_pending)
               | (target_split_ack & (split_pending | (state != ST_INIT_OWN)))
               | (|stray_done);
    case (state)
      ST_IDLE: begin
        if (split_req && split_pending) begin
          sgrant_nxt = 1'b1;
          state_nxt  = ST_SPLIT_OWN;
        end else if (win_vld) begin
          grant_nxt = {{(NUM_INIT-1){1'b0}}, 1'b1} << win_idx;
          own_nxt   = win_idx;
          hold_nxt  = '0;
          state_nxt = ST_INIT_OWN;
        end
      end
      ST_INIT_OWN: begin
        // A split ack wins over a simultaneous release; a second split while one is parked is ignored.
        if (target_split_ack && !split_pending) begin
          sowner_nxt = own_idx;
          spend_nxt  = 1'b1;
          grant_nxt  = '0;
          state_nxt  = ST_IDLE;
        end else if (init_done[own_idx]) begin
          grant_nxt = '0;
          state_nxt = ST_IDLE;
        end else if (HOLD_TIMEOUT > 0) begin
          if (hold_cnt == HCW'(HOLD_TIMEOUT - 1)) begin
            grant_nxt = '0;
            tmo_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            hold_nxt = hold_cnt + HCW'(1);
          end
        end
      end
      ST_SPLIT_OWN: begin
        if (target_ack) begin
          sgrant_nxt = 1'b0;
          spend_nxt  = 1'b0;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    busy_nxt = (|grant_nxt) | sgrant_nxt;
  end

  // rst_n is expected to be released synchronously to clk by the reset controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_idx       <= '0;
      hold_cnt      <= '0;
      init_grant    <= '0;
      split_grant   <= 1'b0;
      split_owner   <= '0;
      split_pending <= 1'b0;
      bus_busy      <= 1'b0;
      arb_timeout   <= 1'b0;
      split_err     <= 1'b0;
    end else begin
      own_idx       <= own_nxt;
      hold_cnt      <= hold_nxt;
      init_grant    <= grant_nxt;
      split_grant   <= sgrant_nxt;
      split_owner   <= sowner_nxt;
      split_pending <= spend_nxt;
      bus_busy      <= busy_nxt;
      arb_timeout   <= tmo_nxt;
      split_err     <= err_nxt;
    end
  end
endmodule
